// File: rtl/execute_stage.sv
// EX stage of the 5-stage RISC-V pipeline: operand forwarding, ALU, beq resolution and the
// EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] diff;
  logic            overflow;
  logic            less;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Select 11 falls through to the register-file value.
  always_comb begin
    unique case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    unique case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  // Signed less-than from the subtraction flags: N xor V.
  assign diff     = src_a - src_b;
  assign overflow = (src_a[XLEN-1] != src_b[XLEN-1]) && (diff[XLEN-1] != src_a[XLEN-1]);
  assign less     = diff[XLEN-1] ^ overflow;

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = diff;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, less};
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expected EX/MEM contents, a monitor pops
// and compares them after each capturing edge; combinational branch outputs are checked inline.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [31:0] wd;
    logic [31:0] alu;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    nchecks = 0;
  int    nerrors = 0;

  execute_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .ResultSrcE  (ResultSrcE),
    .BranchE     (BranchE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .RD1_E       (RD1_E),
    .RD2_E       (RD2_E),
    .Imm_Ext_E   (Imm_Ext_E),
    .RD_E        (RD_E),
    .PCE         (PCE),
    .PCPlus4E    (PCPlus4E),
    .ForwardA_E  (ForwardA_E),
    .ForwardB_E  (ForwardB_E),
    .ResultW     (ResultW),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_m_zero(input string name);
    chk({name, ".RegWriteM"}, {31'b0, RegWriteM}, 32'h0);
    chk({name, ".MemWriteM"}, {31'b0, MemWriteM}, 32'h0);
    chk({name, ".ResultSrcM"}, {31'b0, ResultSrcM}, 32'h0);
    chk({name, ".RD_M"}, {27'b0, RD_M}, 32'h0);
    chk({name, ".PCPlus4M"}, PCPlus4M, 32'h0);
    chk({name, ".WriteDataM"}, WriteDataM, 32'h0);
    chk({name, ".ALU_ResultM"}, ALU_ResultM, 32'h0);
  endtask

  // Controls and PC+4 are the values the bench itself is driving this cycle.
  task automatic push(input string name, input logic [31:0] e_alu, input logic [31:0] e_wd);
    exp_t e;
    e.rw  = RegWriteE;
    e.mw  = MemWriteE;
    e.rs  = ResultSrcE;
    e.rd  = RD_E;
    e.pc4 = PCPlus4E;
    e.wd  = e_wd;
    e.alu = e_alu;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Plain register-register op, no forwarding; caller has already waited for the negedge.
  task automatic vec(input string name, input logic [2:0] ctl, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e_alu);
    ALUControlE = ctl;
    RD1_E       = a;
    RD2_E       = b;
    ALUSrcE     = 1'b0;
    ForwardA_E  = 2'b00;
    ForwardB_E  = 2'b00;
    PCPlus4E    = PCPlus4E + 32'd4;
    push(name, e_alu, b);
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk({n, ".RegWriteM"}, {31'b0, RegWriteM}, {31'b0, e.rw});
        chk({n, ".MemWriteM"}, {31'b0, MemWriteM}, {31'b0, e.mw});
        chk({n, ".ResultSrcM"}, {31'b0, ResultSrcM}, {31'b0, e.rs});
        chk({n, ".RD_M"}, {27'b0, RD_M}, {27'b0, e.rd});
        chk({n, ".PCPlus4M"}, PCPlus4M, e.pc4);
        chk({n, ".WriteDataM"}, WriteDataM, e.wd);
        chk({n, ".ALU_ResultM"}, ALU_ResultM, e.alu);
      end
    end
  end

  initial begin : stimulus
    rst         = 1'b1;
    RegWriteE   = 1'b1;
    MemWriteE   = 1'b0;
    ResultSrcE  = 1'b1;
    BranchE     = 1'b0;
    ALUSrcE     = 1'b0;
    ALUControlE = 3'b000;
    RD1_E       = 32'h10;
    RD2_E       = 32'h20;
    Imm_Ext_E   = 32'h0;
    RD_E        = 5'd5;
    PCE         = 32'h0;
    PCPlus4E    = 32'h104;
    ForwardA_E  = 2'b00;
    ForwardB_E  = 2'b00;
    ResultW     = 32'h0;

    repeat (2) @(negedge clk);
    chk_m_zero("reset_hold");

    // First edge after release captures the pending inputs.
    @(negedge clk);
    rst = 1'b0;
    push("first_capture", 32'h30, 32'h20);

    // Asynchronous reset between edges clears M immediately.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_m_zero("async_reset");

    @(negedge clk);
    rst        = 1'b0;
    RegWriteE  = 1'b0;
    ResultSrcE = 1'b0;
    RD_E       = 5'd0;
    PCPlus4E   = 32'h0;
    vec("add", 3'b000, 32'h0F, 32'h03, 32'h12);
    @(negedge clk); vec("sub", 3'b001, 32'h0F, 32'h03, 32'h0C);
    @(negedge clk); vec("and", 3'b010, 32'h0F, 32'h03, 32'h03);
    @(negedge clk); vec("or",  3'b011, 32'h0F, 32'h03, 32'h0F);
    @(negedge clk); vec("slt", 3'b101, 32'h0F, 32'h03, 32'h0);
    @(negedge clk); vec("rsv110", 3'b110, 32'h0F, 32'h03, 32'h0);
    @(negedge clk); vec("rsv100", 3'b100, 32'h0F, 32'h03, 32'h0);
    @(negedge clk); vec("slt_neg", 3'b101, 32'h80000000, 32'h1, 32'h1);
    @(negedge clk); vec("slt_ovf", 3'b101, 32'h7FFFFFFF, 32'h80000000, 32'h0);
    @(negedge clk); vec("add_wrap", 3'b000, 32'hFFFFFFFF, 32'h1, 32'h0);

    // Back-to-back dependent ops through the M-stage forward path.
    @(negedge clk); vec("fwd_src", 3'b000, 32'd5, 32'd7, 32'd12);
    @(negedge clk);
    ForwardA_E = 2'b10;
    RD1_E      = 32'h0;
    ALUSrcE    = 1'b1;
    Imm_Ext_E  = 32'h1;
    PCPlus4E   = PCPlus4E + 32'd4;
    push("fwdA_mem", 32'd13, 32'd7);
    @(negedge clk);
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b01;
    ResultW    = 32'hAA;
    push("fwdB_wb", 32'h1, 32'hAA);
    @(negedge clk);
    ForwardA_E = 2'b11;
    ForwardB_E = 2'b00;
    RD1_E      = 32'h3;
    push("fwdA_11", 32'h4, 32'd7);

    // beq taken, then not taken, checked within the EX cycle.
    @(negedge clk);
    BranchE = 1'b1;
    vec("beq_eq", 3'b001, 32'h40, 32'h40, 32'h0);
    PCE       = 32'h100;
    Imm_Ext_E = 32'hFFFFFFF8;
    #1;
    chk("beq_eq.PCSrcE", {31'b0, PCSrcE}, 32'h1);
    chk("beq_eq.PCTargetE", PCTargetE, 32'hF8);
    @(negedge clk);
    vec("beq_ne", 3'b001, 32'h40, 32'h41, 32'hFFFFFFFF);
    #1;
    chk("beq_ne.PCSrcE", {31'b0, PCSrcE}, 32'h0);
    chk("beq_ne.PCTargetE", PCTargetE, 32'hF8);

    // Control propagation followed by a bubble.
    @(negedge clk);
    BranchE    = 1'b0;
    RegWriteE  = 1'b1;
    MemWriteE  = 1'b1;
    ResultSrcE = 1'b1;
    RD_E       = 5'd9;
    vec("ctl", 3'b011, 32'h100, 32'h1, 32'h101);
    @(negedge clk);
    RegWriteE  = 1'b0;
    MemWriteE  = 1'b0;
    ResultSrcE = 1'b0;
    vec("bubble", 3'b000, 32'h2, 32'h2, 32'h4);

    // Drain the scoreboard within a bounded number of edges.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    nchecks++;
    if (exp_q.size() != 0) begin
      nerrors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the 5-stage RISC-V pipeline, together with the EX/MEM pipeline register. It consumes the 3-bit ALU control code produced by the ALU decoder in the decode path, along with the ID/EX operands.
- Resolves operand forwarding.
- Performs the ALU operation.
- Resolves `beq` branches and computes the branch target.
- Registers the results for the memory stage.

Branch redirect is combinational in EX. Everything destined for MEM appears one clock later.

## Interface
Parameters:
- `XLEN`, 32, datapath width

Ports:
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `RegWriteE` in 1: register-file write enable
- `MemWriteE` in 1: data-memory write enable
- `ResultSrcE` in 1: writeback select; 0 = ALU, 1 = memory
- `BranchE` in 1: instruction is `beq`
- `ALUSrcE` in 1: ALU B operand select; 0 = forwarded RD2, 1 = immediate
- `ALUControlE` in 3: 000 add, 001 sub, 010 and, 011 or, 101 slt; others reserved
- `RD1_E`, `RD2_E` in XLEN: register-file read data
- `Imm_Ext_E` in XLEN: sign-extended immediate
- `RD_E` in 5: destination register
- `PCE`, `PCPlus4E` in XLEN: PC of the instruction, and PC+4
- `ForwardA_E`, `ForwardB_E` in 2: forwarding selects from the hazard unit
- `ResultW` in XLEN: writeback-stage result
- `PCSrcE` out 1: branch taken (combinational)
- `PCTargetE` out XLEN: branch target (combinational)
- `RegWriteM`, `MemWriteM`, `ResultSrcM` out 1: registered control
- `RD_M` out 5: registered destination register
- `PCPlus4M`, `WriteDataM`, `ALU_ResultM` out XLEN: registered data

## Operation
Forwarding muxes, applied to both operands:
- `SrcA` = `RD1_E` when `ForwardA_E` = 00; `ResultW` when 01; `ALU_ResultM` (this block's own register output) when 10.
- Select 11 is treated as 00.
- `ForwardB_E` selects the same way among `RD2_E`, `ResultW` and `ALU_ResultM`, giving `FwdB`.
- `SrcB` = `ALUSrcE` ? `Imm_Ext_E` : `FwdB`.

ALU (combinational):
- add: `SrcA`+`SrcB`, modulo 2^XLEN, no overflow trap.
- sub: `SrcA`−`SrcB`, modulo 2^XLEN.
- and / or: bitwise.
- slt: result = 1 if `SrcA` < `SrcB` signed, else 0. The comparison is computed from the subtraction as N xor V, not as a raw sign bit.
- Reserved codes (100, 110, 111): result 0.
- `Zero` = (ALU result == 0).

Branch:
- `PCSrcE` = `BranchE` & `Zero`. The branch is only meaningful with `ALUControlE` = 001, but no check is made.
- `PCTargetE` = `PCE` + `Imm_Ext_E`, modulo 2^XLEN.

EX/MEM register:
- On each rising edge it captures `RegWriteE`, `MemWriteE`, `ResultSrcE`, `RD_E`, `PCPlus4E`, `FwdB` (into `WriteDataM`) and the ALU result (into `ALU_ResultM`).
- `WriteDataM` always carries the forwarded RD2, never the immediate.
- There is no stall or enable. A bubble is inserted upstream by zeroing the E-side controls.

Reset:
- `rst` high clears all M outputs to 0 immediately, regardless of `clk`.
- Reset is held while high. The first capture occurs on the first rising edge after `rst` falls.
- Asserting reset mid-operation discards the in-flight EX/MEM contents. The combinational outputs keep following their inputs.

## Timing
- `PCSrcE` and `PCTargetE`: zero-cycle latency from E inputs, within the EX cycle.
- M outputs: one-cycle latency; valid after the rising edge that closes the EX cycle.
- Forward select 10 uses the value currently on `ALU_ResultM`, i.e. the previous instruction's result. This gives back-to-back dependent ALU ops with no stall.
- Combinational path to budget: `ALU_ResultM` → forward mux → ALU → `Zero` → `PCSrcE`.
- Load-use hazards are the hazard unit's responsibility, not this block's.

## Test plan
- Reset:
  - Drive nonzero E inputs.
  - Assert `rst` asynchronously between edges → all M outputs read 0 before the next edge.
  - Deassert `rst` → the first edge captures the E inputs.
- ALU codes, with `RD1_E`=0x0000000F, `RD2_E`=0x00000003, `ALUSrcE`=0, forwards 00:
  - 000 → `ALU_ResultM`=0x12
  - 001 → 0x0C
  - 010 → 0x03
  - 011 → 0x0F
  - 101 → 0x0
  - 110 → 0x0
- slt signed and wrap:
  - `RD1_E`=0x80000000, `RD2_E`=0x00000001, slt → 1.
  - Add with `RD1_E`=0xFFFFFFFF, `RD2_E`=1 → 0x00000000.
- Forwarding:
  - Cycle 1: add with `RD1_E`=5, `RD2_E`=7.
  - Cycle 2: `ForwardA_E`=10, `RD1_E`=0, `ALUSrcE`=1, `Imm_Ext_E`=1, add → `ALU_ResultM`=13.
  - `ForwardB_E`=01 with `ResultW`=0xAA → `WriteDataM`=0xAA.
- Branch:
  - `BranchE`=1, sub, `RD1_E`=`RD2_E`=0x40, `PCE`=0x100, `Imm_Ext_E`=0xFFFFFFF8 → same cycle `PCSrcE`=1, `PCTargetE`=0xF8.
  - Change `RD2_E` to 0x41 → `PCSrcE`=0.
- Control and bubble:
  - `RegWriteE`=1, `MemWriteE`=1, `ResultSrcE`=1, `RD_E`=9 → these appear on the M outputs one edge later.
  - Next cycle, all E controls = 0 → `RegWriteM`=`MemWriteM`=0 after the following edge.
